alu_multicycle: RTL and testbench



---
 rtl/alu_multicycle.sv | 134 +++++++++++++
 tb/tb_alu_multicycle.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle logic/arith ops, DATA_WIDTH-cycle shift-add MULTU.
// Latency: done_o at N+2 (single-cycle ops) or N+DATA_WIDTH+2 (MULTU); start_i ignored unless IDLE.
module alu_multicycle #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            alu_operation_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] alu_data_o,
    output logic [DATA_WIDTH-1:0] hi_data_o,
    output logic                  zero_o,
    output logic                  illegal_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_LUI   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_MULTU = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [PW-1:0]         acc;
    logic [PW-1:0]         mcand;
    logic [DATA_WIDTH-1:0] mplier;

    logic [DATA_WIDTH-1:0] single_res;
    logic                  single_ill;
    logic [PW-1:0]         acc_sum;

    always_comb begin
        single_res = '0;
        single_ill = 1'b0;
        case (alu_operation_i)
            OP_AND: single_res = a_data_i & b_data_i;
            OP_OR:  single_res = a_data_i | b_data_i;
            OP_ADD: single_res = a_data_i + b_data_i;
            OP_SUB: single_res = a_data_i - b_data_i;
            OP_SLT: single_res = {{(DATA_WIDTH-1){1'b0}},
                                  ($signed(a_data_i) < $signed(b_data_i))};
            OP_LUI: single_res = {b_data_i[15:0], {(DATA_WIDTH-16){1'b0}}};
            default: begin
                single_res = '0;
                single_ill = 1'b1;
            end
        endcase
    end

    // One multiplier bit per cycle, LSB first; multiplicand pre-shifted each step.
    always_comb begin
        acc_sum = acc;
        if (mplier[0]) begin
            acc_sum = acc + mcand;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            alu_data_o <= '0;
            hi_data_o  <= '0;
            zero_o     <= 1'b0;
            illegal_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (alu_operation_i == OP_MULTU) begin
                            acc    <= '0;
                            mcand  <= {{DATA_WIDTH{1'b0}}, a_data_i};
                            mplier <= b_data_i;
                            count  <= '0;
                            state  <= MUL;
                        end else begin
                            alu_data_o <= single_res;
                            zero_o     <= (single_res == '0);
                            illegal_o  <= single_ill;
                            state      <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(DATA_WIDTH - 1)) begin
                        alu_data_o <= acc_sum[DATA_WIDTH-1:0];
                        hi_data_o  <= acc_sum[PW-1:DATA_WIDTH];
                        zero_o     <= (acc_sum[DATA_WIDTH-1:0] == '0);
                        illegal_o  <= 1'b0;
                        count      <= '0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed vector table plus randomized operations against a plain-arithmetic model.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a_in, b_in;
    logic        busy, done, zero, ill;
    logic [31:0] res, hi;

    int total = 0;
    int bad   = 0;
    logic [31:0] hi_model = '0;

    alu_multicycle #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(rst_n), .start_i(start), .alu_operation_i(op),
        .a_data_i(a_in), .b_data_i(b_in), .busy_o(busy), .done_o(done),
        .alu_data_o(res), .hi_data_o(hi), .zero_o(zero), .illegal_o(ill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        int          pulse_k;
        logic [31:0] er, eh;
        logic        ez, ei;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int pulse_k, input logic [31:0] er,
                          input logic [31:0] eh, input logic ez, input logic ei, input int lat);
        int  k;
        bit  busy_ok;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(negedge clk);
        k = 1;
        busy_ok = 1'b1;
        start = 1'b0; a_in = $urandom; b_in = $urandom; op = 4'($urandom);
        while (!done && k < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (k == pulse_k) begin
                start = 1'b1; op = 4'b0011;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({name, ".latency"}, 64'(k), 64'(lat));
        check({name, ".busy_during"}, 64'(busy_ok), 64'd1);
        check({name, ".busy_at_done"}, 64'(busy), 64'd0);
        check({name, ".result"}, 64'(res), 64'(er));
        check({name, ".hi"}, 64'(hi), 64'(eh));
        check({name, ".zero"}, 64'(zero), 64'(ez));
        check({name, ".illegal"}, 64'(ill), 64'(ei));
        @(negedge clk);
        check({name, ".done_one_cycle"}, 64'(done), 64'd0);
    endtask

    // Reference: direct arithmetic on the operation's meaning.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] er, output logic ei, output int lat);
        logic [63:0] p;
        ei = 1'b0;
        lat = 2;
        er = '0;
        case (o)
            4'b0011: er = a + b;
            4'b0001: er = a - b;
            4'b0000: er = a & b;
            4'b0010: er = a | b;
            4'b0101: er = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0100: er = b << 16;
            4'b0110: begin
                p = 64'(a) * 64'(b);
                er = p[31:0];
                hi_model = p[63:32];
                lat = 34;
            end
            default: ei = 1'b1;
        endcase
    endtask

    initial begin
        logic [31:0] er;
        logic        ei;
        int          lat;
        logic [3:0]  o;
        logic [31:0] a, b;
        int          k;
        bit          saw_done;

        vecs[0] = '{4'b0011, 32'd7, 32'd5, 0, 32'd12, 32'd0, 1'b0, 1'b0, 2};
        vecs[1] = '{4'b0001, 32'd5, 32'd5, 0, 32'd0, 32'd0, 1'b1, 1'b0, 2};
        vecs[2] = '{4'b0001, 32'd0, 32'd1, 0, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 2};
        vecs[3] = '{4'b0101, 32'hFFFFFFFF, 32'd1, 0, 32'd1, 32'd0, 1'b0, 1'b0, 2};
        vecs[4] = '{4'b0110, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFE, 32'd1, 1'b0, 1'b0, 34};
        vecs[5] = '{4'b0100, 32'hDEAD0000, 32'h00001234, 0, 32'h12340000, 32'd1, 1'b0, 1'b0, 2};
        vecs[6] = '{4'b1001, 32'd3, 32'd4, 0, 32'd0, 32'd1, 1'b1, 1'b1, 2};
        vecs[7] = '{4'b0011, 32'd1, 32'd1, 0, 32'd2, 32'd1, 1'b0, 1'b0, 2};
        vecs[8] = '{4'b0000, 32'hF0F01234, 32'h0FF0FF00, 0, 32'h00F01200, 32'd1, 1'b0, 1'b0, 2};
        vecs[9] = '{4'b0010, 32'hF0000000, 32'h0000000F, 0, 32'hF000000F, 32'd1, 1'b0, 1'b0, 2};

        rst_n = 1'b0; start = 1'b0; op = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.result", 64'(res), 64'd0);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.zero_ill", 64'({zero, ill}), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pulse_k,
                   vecs[i].er, vecs[i].eh, vecs[i].ez, vecs[i].ei, vecs[i].lat);
        end
        hi_model = 32'd1;

        // Abort a multiply partway through with reset.
        @(negedge clk);
        start = 1'b1; op = 4'b0110; a_in = 32'h12345678; b_in = 32'h9ABCDEF1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.outputs", {res, hi}, 64'd0);
        check("abort.flags", 64'({done, zero, ill}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hi_model = '0;
        saw_done = 1'b0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort.no_done", 64'(saw_done), 64'd0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) o = 4'($urandom_range(7, 15));
            else o = 4'($urandom_range(0, 6));
            a = $urandom;
            b = (n % 5 == 0) ? a : $urandom;
            model(o, a, b, er, ei, lat);
            run_op($sformatf("rnd%0d_op%0d", n, o), o, a, b, 0, er, hi_model,
                   (er == 32'd0), ei, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
